// File: rtl/prv664_pkg.sv
// Shared prv664 definitions: address width default and the BPU update entry.
`ifndef XLEN
`define XLEN 32
`endif

package prv664_pkg;

    localparam int unsigned BRTYPE_W = 3;

    // One pending predictor update as held in the update queue.
    typedef struct packed {
        logic [`XLEN-1:0]    pc;
        logic [`XLEN-1:0]    predictedpc;
        logic [BRTYPE_W-1:0] branchtype;
        logic                predictbit;
        logic                alloc;
    } bpu_upd_entry_t;

    // Build a queue entry from a resolved commit.
    function automatic bpu_upd_entry_t make_entry(
        input logic [`XLEN-1:0]    pc,
        input logic [`XLEN-1:0]    target,
        input logic [BRTYPE_W-1:0] btype,
        input logic                taken
    );
        bpu_upd_entry_t e;
        e.pc          = pc;
        e.predictedpc = target;
        e.branchtype  = btype;
        e.predictbit  = taken;
        e.alloc       = taken;
        return e;
    endfunction

endpackage

// File: rtl/bpuupd_interface.sv
// BPU update port bundle; the update queue drives it as master.
interface bpuupd_interface #(
    parameter int unsigned XLEN = `XLEN
);
    logic            valid;
    logic            wr_req;
    logic [XLEN-1:0] wr_pc;
    logic [XLEN-1:0] wr_predictedpc;
    logic [2:0]      wr_branchtype;
    logic            wr_predictbit;

    modport master (
        output valid, wr_req, wr_pc, wr_predictedpc, wr_branchtype, wr_predictbit
    );

    modport slave (
        input valid, wr_req, wr_pc, wr_predictedpc, wr_branchtype, wr_predictbit
    );
endinterface

// File: rtl/bpu_update_queue_filter.sv
// Decides whether a retired branch needs to be written back to the predictor.
module bpuupd_filter #(
    parameter int unsigned XLEN = `XLEN
) (
    input  logic            cmt_valid_i,
    input  logic            cmt_taken_i,
    input  logic            cmt_pred_taken_i,
    input  logic [XLEN-1:0] cmt_target_i,
    input  logic [XLEN-1:0] cmt_pred_pc_i,
    output logic            upd_o
);

    // Update on taken branches, direction mispredicts, or target mispredicts.
    always_comb begin
        upd_o = cmt_valid_i &
                (cmt_taken_i |
                 (cmt_pred_taken_i != cmt_taken_i) |
                 (cmt_taken_i & (cmt_pred_pc_i != cmt_target_i)));
    end

endmodule

// File: rtl/bpu_update_queue.sv
// Decouples commit-time predictor updates from BPU write availability.
// Circular FIFO with youngest-entry coalescing and drop-on-full.
module bpu_update_queue
    import prv664_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = `XLEN
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cmt_valid_i,
    input  logic [XLEN-1:0]        cmt_pc_i,
    input  logic [XLEN-1:0]        cmt_target_i,
    input  logic [2:0]             cmt_branchtype_i,
    input  logic                   cmt_taken_i,
    input  logic                   cmt_pred_taken_i,
    input  logic [XLEN-1:0]        cmt_pred_pc_i,
    input  logic                   bpu_ready_i,
    bpuupd_interface.master        bpuupd,
    output logic [15:0]            drop_cnt_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      drop_cnt_q;

    bpu_upd_entry_t   mem_q [DEPTH];

    logic             upd;
    logic             deq;
    logic             coalesce;
    logic             full;
    logic             enq;
    logic             drop;
    logic             wr_en;
    logic [PTR_W-1:0] young_idx;
    logic [PTR_W-1:0] wr_idx;
    bpu_upd_entry_t   new_ent;
    bpu_upd_entry_t   head_ent;

    logic             valid_q, valid_d;
    logic             wr_req_q, wr_req_d;
    logic [XLEN-1:0]  wr_pc_q, wr_pc_d;
    logic [XLEN-1:0]  wr_predictedpc_q, wr_predictedpc_d;
    logic [2:0]       wr_branchtype_q, wr_branchtype_d;
    logic             wr_predictbit_q, wr_predictbit_d;

    bpuupd_filter #(
        .XLEN(XLEN)
    ) u_filter (
        .cmt_valid_i      (cmt_valid_i),
        .cmt_taken_i      (cmt_taken_i),
        .cmt_pred_taken_i (cmt_pred_taken_i),
        .cmt_target_i     (cmt_target_i),
        .cmt_pred_pc_i    (cmt_pred_pc_i),
        .upd_o            (upd)
    );

    // Queue control: dequeue, coalesce, enqueue/drop decisions and next pointers.
    always_comb begin
        new_ent   = make_entry(cmt_pc_i, cmt_target_i, cmt_branchtype_i, cmt_taken_i);
        deq       = valid_q & bpu_ready_i;
        young_idx = tail_q - PTR_ONE;
        full      = (count_q == CNT_FULL);
        // The youngest entry is only leaving this cycle when it is also the head.
        coalesce  = upd && (count_q != '0) && (mem_q[young_idx].pc == cmt_pc_i) &&
                    !(deq && (count_q == CNT_ONE));
        enq       = upd && !coalesce && (!full || deq);
        drop      = upd && !coalesce && full && !deq;
        wr_en     = coalesce | enq;
        wr_idx    = coalesce ? young_idx : tail_q;

        head_d    = deq ? head_q + PTR_ONE : head_q;
        tail_d    = enq ? tail_q + PTR_ONE : tail_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Next output values from the post-edge head, bypassing a same-cycle write to it.
    always_comb begin
        head_ent         = (wr_en && (wr_idx == head_d)) ? new_ent : mem_q[head_d];
        valid_d          = (count_d != '0);
        wr_req_d         = valid_d & head_ent.alloc;
        wr_pc_d          = valid_d ? head_ent.pc          : '0;
        wr_predictedpc_d = valid_d ? head_ent.predictedpc : '0;
        wr_branchtype_d  = valid_d ? head_ent.branchtype  : '0;
        wr_predictbit_d  = valid_d ? head_ent.predictbit  : 1'b0;
    end

    // Entry storage; contents are only meaningful under the valid/pointer state.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= new_ent;
        end
    end

    // Pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Registered BPU update port.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            valid_q          <= 1'b0;
            wr_req_q         <= 1'b0;
            wr_pc_q          <= '0;
            wr_predictedpc_q <= '0;
            wr_branchtype_q  <= '0;
            wr_predictbit_q  <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            wr_req_q         <= wr_req_d;
            wr_pc_q          <= wr_pc_d;
            wr_predictedpc_q <= wr_predictedpc_d;
            wr_branchtype_q  <= wr_branchtype_d;
            wr_predictbit_q  <= wr_predictbit_d;
        end
    end

    assign bpuupd.valid          = valid_q;
    assign bpuupd.wr_req         = wr_req_q;
    assign bpuupd.wr_pc          = wr_pc_q;
    assign bpuupd.wr_predictedpc = wr_predictedpc_q;
    assign bpuupd.wr_branchtype  = wr_branchtype_q;
    assign bpuupd.wr_predictbit  = wr_predictbit_q;
    assign drop_cnt_o            = drop_cnt_q;
    assign occupancy_o           = count_q;

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed self-checking bench for bpu_update_queue (DEPTH=4, XLEN=32).
module tb_bpu_update_queue;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        cmt_valid_i;
    logic [31:0] cmt_pc_i;
    logic [31:0] cmt_target_i;
    logic [2:0]  cmt_branchtype_i;
    logic        cmt_taken_i;
    logic        cmt_pred_taken_i;
    logic [31:0] cmt_pred_pc_i;
    logic        bpu_ready_i;
    logic [15:0] drop_cnt_o;
    logic [2:0]  occupancy_o;

    int n_asserts = 0;
    int n_fail    = 0;

    bpuupd_interface #(.XLEN(32)) upd_if ();

    bpu_update_queue #(
        .DEPTH(4),
        .XLEN (32)
    ) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .cmt_valid_i      (cmt_valid_i),
        .cmt_pc_i         (cmt_pc_i),
        .cmt_target_i     (cmt_target_i),
        .cmt_branchtype_i (cmt_branchtype_i),
        .cmt_taken_i      (cmt_taken_i),
        .cmt_pred_taken_i (cmt_pred_taken_i),
        .cmt_pred_pc_i    (cmt_pred_pc_i),
        .bpu_ready_i      (bpu_ready_i),
        .bpuupd           (upd_if),
        .drop_cnt_o       (drop_cnt_o),
        .occupancy_o      (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set at a falling edge are captured, outputs sampled at the next falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                          input logic pred_taken, input logic [31:0] pred_pc, input logic [2:0] bt);
        cmt_valid_i      = 1'b1;
        cmt_pc_i         = pc;
        cmt_target_i     = tgt;
        cmt_taken_i      = taken;
        cmt_pred_taken_i = pred_taken;
        cmt_pred_pc_i    = pred_pc;
        cmt_branchtype_i = bt;
    endtask

    task automatic idle();
        cmt_valid_i = 1'b0;
    endtask

    initial begin
        arst_n_i         = 1'b0;
        cmt_valid_i      = 1'b0;
        cmt_pc_i         = '0;
        cmt_target_i     = '0;
        cmt_branchtype_i = '0;
        cmt_taken_i      = 1'b0;
        cmt_pred_taken_i = 1'b0;
        cmt_pred_pc_i    = '0;
        bpu_ready_i      = 1'b0;

        #12;
        check("rst_valid",  upd_if.valid, 1'b0);
        check("rst_wr_req", upd_if.wr_req, 1'b0);
        check("rst_wr_pc",  upd_if.wr_pc, 32'h0);
        check("rst_occ",    occupancy_o, 3'd0);
        check("rst_drop",   drop_cnt_o, 16'd0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        step();

        // Single taken update, one-cycle latency, then drained.
        bpu_ready_i = 1'b1;
        commit(32'h8000_0100, 32'h8000_0200, 1'b1, 1'b0, 32'h0, 3'd2);
        step();
        idle();
        check("t1_valid",  upd_if.valid, 1'b1);
        check("t1_wr_req", upd_if.wr_req, 1'b1);
        check("t1_pc",     upd_if.wr_pc, 32'h8000_0100);
        check("t1_ppc",    upd_if.wr_predictedpc, 32'h8000_0200);
        check("t1_pbit",   upd_if.wr_predictbit, 1'b1);
        check("t1_btype",  upd_if.wr_branchtype, 3'd2);
        check("t1_occ",    occupancy_o, 3'd1);
        step();
        check("t1_drain_valid", upd_if.valid, 1'b0);
        check("t1_drain_occ",   occupancy_o, 3'd0);

        // Correctly predicted not-taken: filtered out.
        commit(32'h8000_0300, 32'h8000_0304, 1'b0, 1'b0, 32'h0, 3'd1);
        step();
        idle();
        check("t2_nt_valid", upd_if.valid, 1'b0);
        check("t2_nt_occ",   occupancy_o, 3'd0);
        // Direction mispredict to not-taken: prediction-bit only update.
        commit(32'h8000_0300, 32'h8000_0304, 1'b0, 1'b1, 32'h8000_0400, 3'd1);
        step();
        idle();
        check("t2_mp_valid",  upd_if.valid, 1'b1);
        check("t2_mp_wr_req", upd_if.wr_req, 1'b0);
        check("t2_mp_pbit",   upd_if.wr_predictbit, 1'b0);
        check("t2_mp_pc",     upd_if.wr_pc, 32'h8000_0300);
        step();
        check("t2_drain_valid", upd_if.valid, 1'b0);

        // Six distinct updates while stalled: four held, two dropped, FIFO drain.
        bpu_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            commit(32'h4000 + 32'(k) * 32'h10, 32'h9000 + 32'(k) * 32'h10, 1'b1, 1'b1, 32'h0, 3'd0);
            step();
        end
        idle();
        check("t3_occ",  occupancy_o, 3'd4);
        check("t3_drop", drop_cnt_o, 16'd2);
        check("t3_head", upd_if.wr_pc, 32'h4000);
        bpu_ready_i = 1'b1;
        check("t3_pc0", upd_if.wr_pc, 32'h4000);
        step();
        check("t3_pc1", upd_if.wr_pc, 32'h4010);
        check("t3_ppc1", upd_if.wr_predictedpc, 32'h9010);
        step();
        check("t3_pc2", upd_if.wr_pc, 32'h4020);
        step();
        check("t3_pc3", upd_if.wr_pc, 32'h4030);
        check("t3_occ3", occupancy_o, 3'd1);
        step();
        check("t3_empty", upd_if.valid, 1'b0);
        check("t3_drop_keep", drop_cnt_o, 16'd2);

        // Back-to-back same pc while stalled: coalesced in place.
        bpu_ready_i = 1'b0;
        commit(32'h1000, 32'h2000, 1'b1, 1'b1, 32'h0, 3'd0);
        step();
        commit(32'h1000, 32'h3000, 1'b1, 1'b1, 32'h0, 3'd0);
        step();
        idle();
        check("t4_occ", occupancy_o, 3'd1);
        check("t4_ppc", upd_if.wr_predictedpc, 32'h3000);
        bpu_ready_i = 1'b1;
        step();
        check("t4_empty", upd_if.valid, 1'b0);

        // Same pc while the sole entry is leaving: enqueued fresh, not coalesced.
        commit(32'h5000, 32'h5100, 1'b1, 1'b1, 32'h0, 3'd0);
        step();
        check("t4b_ppc_a", upd_if.wr_predictedpc, 32'h5100);
        commit(32'h5000, 32'h5200, 1'b1, 1'b1, 32'h0, 3'd0);
        step();
        idle();
        check("t4b_occ",   occupancy_o, 3'd1);
        check("t4b_ppc_b", upd_if.wr_predictedpc, 32'h5200);
        step();
        check("t4b_empty", upd_if.valid, 1'b0);

        // Full queue with simultaneous dequeue and enqueue.
        bpu_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            commit(32'h6000 + 32'(k) * 32'h10, 32'h7000 + 32'(k) * 32'h10, 1'b1, 1'b1, 32'h0, 3'd0);
            step();
        end
        idle();
        check("t5_full_occ", occupancy_o, 3'd4);
        bpu_ready_i = 1'b1;
        commit(32'h6040, 32'h7040, 1'b1, 1'b1, 32'h0, 3'd0);
        step();
        idle();
        bpu_ready_i = 1'b0;
        check("t5_occ",  occupancy_o, 3'd4);
        check("t5_drop", drop_cnt_o, 16'd2);
        check("t5_head", upd_if.wr_pc, 32'h6010);
        bpu_ready_i = 1'b1;
        step();
        check("t5_pc2", upd_if.wr_pc, 32'h6020);
        step();
        check("t5_pc3", upd_if.wr_pc, 32'h6030);
        step();
        check("t5_last", upd_if.wr_pc, 32'h6040);
        check("t5_last_ppc", upd_if.wr_predictedpc, 32'h7040);
        step();
        check("t5_empty", upd_if.valid, 1'b0);

        // Asynchronous reset with three entries queued.
        bpu_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            commit(32'hA000 + 32'(k) * 32'h10, 32'hB000, 1'b1, 1'b1, 32'h0, 3'd0);
            step();
        end
        idle();
        check("t6_pre_occ", occupancy_o, 3'd3);
        #2;
        arst_n_i = 1'b0;
        #1;
        check("t6_rst_valid", upd_if.valid, 1'b0);
        check("t6_rst_occ",   occupancy_o, 3'd0);
        check("t6_rst_drop",  drop_cnt_o, 16'd0);
        check("t6_rst_pc",    upd_if.wr_pc, 32'h0);
        @(negedge clk_i);
        arst_n_i    = 1'b1;
        bpu_ready_i = 1'b1;
        step();
        check("t6_post_valid",  upd_if.valid, 1'b0);
        check("t6_post_wr_req", upd_if.wr_req, 1'b0);
        check("t6_post_occ",    occupancy_o, 3'd0);
        step();
        check("t6_post2_valid", upd_if.valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
